// File: rtl/mem_bus_responder_if.sv
// CPU-side bus of the mem_bus_responder: the signals the top8227 bus master drives and receives.
// Handshake: ready is high for exactly one clock per bus cycle. Address, readNotWrite, dataBusOutput and dataBusEnable are sampled only at the end of that cycle's first clock. dataBusInput is valid while ready is high.
interface mem_bus_responder_if;
    logic [7:0] addressBusHigh;
    logic [7:0] addressBusLow;
    logic       readNotWrite;
    logic [7:0] dataBusOutput;
    logic       dataBusEnable;
    logic [7:0] dataBusInput;
    logic       ready;

    modport master (
        output addressBusHigh,
        output addressBusLow,
        output readNotWrite,
        output dataBusOutput,
        output dataBusEnable,
        input  dataBusInput,
        input  ready
    );

    modport slave (
        input  addressBusHigh,
        input  addressBusLow,
        input  readNotWrite,
        input  dataBusOutput,
        input  dataBusEnable,
        output dataBusInput,
        output ready
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the top8227 bus: SRAM or vector ROM, stretched with ready (3 + WAIT_STATES clocks).
// Optional macro WRITE_PROTECT_EN suppresses writes at or above ROM_BASE and flags them on wp_violation.
module mem_bus_responder #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [15:0] RST_VECTOR  = 16'hCCF0,
    parameter logic [15:0] NMI_VECTOR  = 16'hAA00,
    parameter logic [15:0] IRQ_VECTOR  = 16'hBB00,
    parameter logic [15:0] ROM_BASE    = 16'hF000
) (
    input  logic                clk,
    input  logic                nrst,
    mem_bus_responder_if.slave  bus,
    output logic [15:0]         sram_addr,
    output logic [7:0]          sram_wdata,
    output logic                sram_re,
    output logic                sram_we,
    input  logic [7:0]          sram_rdata,
`ifdef WRITE_PROTECT_EN
    output logic                wp_violation,
`endif
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned WAIT_LAST_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  WAIT_LAST   = 4'(WAIT_LAST_I);
`ifdef WRITE_PROTECT_EN
    localparam logic WP_ON = 1'b1;
`else
    localparam logic WP_ON = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic        hit_q, hit_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  dbi_q, dbi_d;
`ifdef WRITE_PROTECT_EN
    logic        wp_q, wp_d;
`endif

    logic [15:0] bus_addr;
    logic        bus_hit;
    logic        wr_req;
    logic        wr_block;

    assign bus_addr = {bus.addressBusHigh, bus.addressBusLow};
    assign bus_hit  = (bus_addr >= 16'hFFFA);
    assign wr_req   = ~bus.readNotWrite & bus.dataBusEnable & ~bus_hit;
    assign wr_block = WP_ON & (bus_addr >= ROM_BASE);

    // Only the low three address bits distinguish FFFA..FFFF.
    function automatic logic [7:0] vector_byte(input logic [2:0] sel);
        case (sel)
            3'b010:  return NMI_VECTOR[7:0];
            3'b011:  return NMI_VECTOR[15:8];
            3'b100:  return RST_VECTOR[7:0];
            3'b101:  return RST_VECTOR[15:8];
            3'b110:  return IRQ_VECTOR[7:0];
            3'b111:  return IRQ_VECTOR[15:8];
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rnw_d      = rnw_q;
        hit_d      = hit_q;
        wdata_d    = wdata_q;
        dbi_d      = dbi_q;
`ifdef WRITE_PROTECT_EN
        wp_d       = wp_q;
`endif
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        sram_re    = 1'b0;
        sram_we    = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                addr_d     = bus_addr;
                rnw_d      = bus.readNotWrite;
                hit_d      = bus_hit;
                wdata_d    = bus.dataBusOutput;
                cnt_d      = 4'd0;
                sram_addr  = bus_addr;
                sram_wdata = bus.dataBusOutput;
                sram_re    = bus.readNotWrite & ~bus_hit;
                sram_we    = wr_req & ~wr_block;
`ifdef WRITE_PROTECT_EN
                wp_d       = wr_req & wr_block;
`endif
                state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_FETCH;
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_FETCH: begin
                if (rnw_q) begin
                    dbi_d = hit_q ? vector_byte(addr_q[2:0]) : sram_rdata;
                end
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase

        // The ISSUE strobes are combinational from the bus, so hold them quiet while reset is asserted.
        if (!nrst) begin
            sram_addr  = 16'h0000;
            sram_wdata = 8'h00;
            sram_re    = 1'b0;
            sram_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_ISSUE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            rnw_q   <= 1'b0;
            hit_q   <= 1'b0;
            wdata_q <= 8'h00;
            dbi_q   <= 8'h00;
`ifdef WRITE_PROTECT_EN
            wp_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            hit_q   <= hit_d;
            wdata_q <= wdata_d;
            dbi_q   <= dbi_d;
`ifdef WRITE_PROTECT_EN
            wp_q    <= wp_d;
`endif
        end
    end

    assign bus.ready        = (state_q == ST_DONE);
    assign bus.dataBusInput = dbi_q;
    assign dbg_state        = state_q;
`ifdef WRITE_PROTECT_EN
    assign wp_violation     = wp_q & (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a WAIT_STATES=0 instance for vector reads, a WAIT_STATES=2 instance with an SRAM model for everything else.
module tb_mem_bus_responder;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] cpu_addr;
    logic        cpu_rnw;
    logic [7:0]  cpu_wdata;
    logic        cpu_dbe;

    mem_bus_responder_if bus0();
    mem_bus_responder_if bus2();

    assign bus0.addressBusHigh = cpu_addr[15:8];
    assign bus0.addressBusLow  = cpu_addr[7:0];
    assign bus0.readNotWrite   = cpu_rnw;
    assign bus0.dataBusOutput  = cpu_wdata;
    assign bus0.dataBusEnable  = cpu_dbe;
    assign bus2.addressBusHigh = cpu_addr[15:8];
    assign bus2.addressBusLow  = cpu_addr[7:0];
    assign bus2.readNotWrite   = cpu_rnw;
    assign bus2.dataBusOutput  = cpu_wdata;
    assign bus2.dataBusEnable  = cpu_dbe;

    logic [15:0] s0_addr, s2_addr;
    logic [7:0]  s0_wdata, s2_wdata, s2_rdata;
    logic        s0_re, s0_we, s2_re, s2_we;
    logic [1:0]  st0, st2;
    logic        wp0, wp2;

    mem_bus_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .nrst(nrst), .bus(bus0),
        .sram_addr(s0_addr), .sram_wdata(s0_wdata), .sram_re(s0_re), .sram_we(s0_we),
        .sram_rdata(8'h3C),
`ifdef WRITE_PROTECT_EN
        .wp_violation(wp0),
`endif
        .dbg_state(st0)
    );

    mem_bus_responder #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .nrst(nrst), .bus(bus2),
        .sram_addr(s2_addr), .sram_wdata(s2_wdata), .sram_re(s2_re), .sram_we(s2_we),
        .sram_rdata(s2_rdata),
`ifdef WRITE_PROTECT_EN
        .wp_violation(wp2),
`endif
        .dbg_state(st2)
    );

`ifndef WRITE_PROTECT_EN
    assign wp0 = 1'b0;
    assign wp2 = 1'b0;
`endif

    // Synchronous SRAM model behind dut2, with a back door for preloading.
    logic [7:0]  mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_a;
    logic [7:0]  pre_d;
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (s2_we) mem[s2_addr] <= s2_wdata;
        if (s2_re) s2_rdata <= mem[s2_addr];
    end

    logic        sel;
    logic [1:0]  m_state;
    logic        m_ready, m_re, m_we, m_wp;
    logic [7:0]  m_dbi, m_swdata;
    logic [15:0] m_saddr;
    assign m_state  = sel ? st2 : st0;
    assign m_ready  = sel ? bus2.ready : bus0.ready;
    assign m_dbi    = sel ? bus2.dataBusInput : bus0.dataBusInput;
    assign m_re     = sel ? s2_re : s0_re;
    assign m_we     = sel ? s2_we : s0_we;
    assign m_saddr  = sel ? s2_addr : s0_addr;
    assign m_swdata = sel ? s2_wdata : s0_wdata;
    assign m_wp     = sel ? wp2 : wp0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic bus_idle();
        cpu_addr  = 16'h0000;
        cpu_rnw   = 1'b1;
        cpu_wdata = 8'h00;
        cpu_dbe   = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s);
        int guard = 0;
        while (m_state != s && guard < 20) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // One bus cycle on the selected instance, observed from its ISSUE clock through DONE.
    task automatic bus_cycle(input string tag, input logic [15:0] a, input logic rnw,
                             input logic dbe, input logic [7:0] wd, input logic glitch,
                             output int lat, output int n_re, output int n_we, output int n_wp,
                             output logic [15:0] st_addr, output logic [7:0] st_wdata,
                             output logic [7:0] dbi);
        logic ok;
        lat = 0; n_re = 0; n_we = 0; n_wp = 0;
        st_addr = '0; st_wdata = '0; dbi = '0; ok = 1'b0;
        @(negedge clk);
        wait_state(2'd0);
        cpu_addr  = a;
        cpu_rnw   = rnw;
        cpu_dbe   = dbe;
        cpu_wdata = wd;
        #1;
        for (int k = 0; k < 30 && !ok; k++) begin
            if (m_re) begin n_re++; st_addr = m_saddr; end
            if (m_we) begin n_we++; st_addr = m_saddr; st_wdata = m_swdata; end
            if (m_wp) n_wp++;
            if (m_ready) begin
                dbi = m_dbi;
                ok  = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
                if (glitch && lat == 1) cpu_addr = 16'h0099;
            end
        end
        check({tag, "_done"}, 32'(ok), 32'd1);
        bus_idle();
    endtask

    int          lat, n_re, n_we, n_wp;
    logic [15:0] st_addr;
    logic [7:0]  st_wdata, dbi;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        nrst = 1'b0;
        sel  = 1'b1;
        bus_idle();
        @(negedge clk);
        preload(16'h0000, 8'h11);
        preload(16'h0099, 8'h88);
        preload(16'h0150, 8'h5C);
        preload(16'hFFF9, 8'hE9);

        // Reset values, with the bus presenting a read that would otherwise strobe.
        check("rst_ready",  32'(bus2.ready), 32'd0);
        check("rst_dbi",    32'(bus2.dataBusInput), 32'h00);
        check("rst_re",     32'(s2_re), 32'd0);
        check("rst_we",     32'(s2_we), 32'd0);
        check("rst_addr",   32'(s2_addr), 32'h0000);
        check("rst_wdata",  32'(s2_wdata), 32'h00);
        check("rst_state",  32'(st2), 32'd0);
        check("rst_ready0", 32'(bus0.ready), 32'd0);
        nrst = 1'b1;

        // WAIT_STATES=0: DONE is the third clock of the bus cycle.
        sel = 1'b0;
        bus_cycle("v_fffc", 16'hFFFC, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("v_fffc_lat", 32'(lat), 32'd2);
        check("v_fffc_re",  32'(n_re), 32'd0);
        check("v_fffc_dbi", 32'(dbi), 32'hF0);
        bus_cycle("v_fffd", 16'hFFFD, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("v_fffd_dbi", 32'(dbi), 32'hCC);
        bus_cycle("s0_rd", 16'h1234, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("s0_rd_re",   32'(n_re), 32'd1);
        check("s0_rd_dbi",  32'(dbi), 32'h3C);

        // WAIT_STATES=2: DONE is the fifth clock.
        sel = 1'b1;
        bus_cycle("rd99", 16'h0099, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rd99_lat",  32'(lat), 32'd4);
        check("rd99_re",   32'(n_re), 32'd1);
        check("rd99_addr", 32'(st_addr), 32'h0099);
        check("rd99_dbi",  32'(dbi), 32'h88);

        bus_cycle("wr200", 16'h0200, 1'b0, 1'b1, 8'h5A, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("wr200_we",    32'(n_we), 32'd1);
        check("wr200_re",    32'(n_re), 32'd0);
        check("wr200_addr",  32'(st_addr), 32'h0200);
        check("wr200_wdata", 32'(st_wdata), 32'h5A);
        check("wr200_dbi",   32'(dbi), 32'h88);
        bus_cycle("rd200", 16'h0200, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rd200_dbi",   32'(dbi), 32'h5A);

        bus_cycle("wrnoen", 16'h0200, 1'b0, 1'b0, 8'hA5, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("wrnoen_we",  32'(n_we), 32'd0);
        check("wrnoen_dbi", 32'(dbi), 32'h5A);
        bus_cycle("rd200b", 16'h0200, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rd200b_dbi", 32'(dbi), 32'h5A);

        bus_cycle("wrvec", 16'hFFFE, 1'b0, 1'b1, 8'h12, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("wrvec_we",   32'(n_we), 32'd0);
        bus_cycle("rdfffe", 16'hFFFE, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rdfffe_re",  32'(n_re), 32'd0);
        check("rdfffe_dbi", 32'(dbi), 32'h00);
        bus_cycle("rdfffb", 16'hFFFB, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rdfffb_dbi", 32'(dbi), 32'hAA);
        bus_cycle("rdffff", 16'hFFFF, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rdffff_dbi", 32'(dbi), 32'hBB);
        bus_cycle("rdfffa", 16'hFFFA, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rdfffa_re",  32'(n_re), 32'd0);
        check("rdfffa_dbi", 32'(dbi), 32'h00);
        bus_cycle("rdfff9", 16'hFFF9, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rdfff9_re",   32'(n_re), 32'd1);
        check("rdfff9_addr", 32'(st_addr), 32'hFFF9);
        check("rdfff9_dbi",  32'(dbi), 32'hE9);
        bus_cycle("rd0000", 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("rd0000_dbi", 32'(dbi), 32'h11);

        // Address moves to 0x0099 during WAIT; data must still come from 0x0150.
        bus_cycle("glitch", 16'h0150, 1'b1, 1'b0, 8'h00, 1'b1, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("glitch_re",   32'(n_re), 32'd1);
        check("glitch_addr", 32'(st_addr), 32'h0150);
        check("glitch_dbi",  32'(dbi), 32'h5C);

        // Reset asserted while in FETCH of a read.
        @(negedge clk);
        wait_state(2'd0);
        cpu_addr = 16'h0099;
        cpu_rnw  = 1'b1;
        @(negedge clk);
        wait_state(2'd2);
        check("midrst_fetch", 32'(m_state), 32'd2);
        nrst = 1'b0;
        #1;
        check("midrst_ready", 32'(m_ready), 32'd0);
        check("midrst_dbi",   32'(m_dbi), 32'h00);
        check("midrst_re",    32'(m_re), 32'd0);
        check("midrst_we",    32'(m_we), 32'd0);
        check("midrst_addr",  32'(m_saddr), 32'h0000);
        check("midrst_state", 32'(m_state), 32'd0);
        @(negedge clk);
        check("midrst_re2",   32'(m_re), 32'd0);
        nrst = 1'b1;
        bus_idle();
        bus_cycle("after", 16'h0099, 1'b1, 1'b0, 8'h00, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("after_lat", 32'(lat), 32'd4);
        check("after_dbi", 32'(dbi), 32'h88);

`ifdef WRITE_PROTECT_EN
        bus_cycle("wpf123", 16'hF123, 1'b0, 1'b1, 8'h77, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("wpf123_we", 32'(n_we), 32'd0);
        check("wpf123_wp", 32'(n_wp), 32'd1);
        bus_cycle("wpefff", 16'hEFFF, 1'b0, 1'b1, 8'h66, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("wpefff_we", 32'(n_we), 32'd1);
        check("wpefff_wp", 32'(n_wp), 32'd0);
`else
        bus_cycle("wrf123", 16'hF123, 1'b0, 1'b1, 8'h77, 1'b0, lat, n_re, n_we, n_wp, st_addr, st_wdata, dbi);
        check("wrf123_we",   32'(n_we), 32'd1);
        check("wrf123_addr", 32'(st_addr), 32'hF123);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
